// File: rtl/buttons_debounce_pkg.sv
// Shared constants and helpers for the pushbutton debounce block.
package buttons_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 12000;   // 1 ms at 12 MHz

   // Smallest r with 2**r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/buttons_debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, level, edge pulses, toggle LED.
module debounce_channel
   import buttons_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_pin,
   output logic o_level,
   output logic o_press,
   output logic o_rel,
   output logic o_led
);

   localparam int                CNT_W   = clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_rel;
   logic             r_led;
   logic             w_s;

   assign w_s = r_sync[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         r_led   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_pin};
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         if (w_s == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            // Input has differed for DEBOUNCE_CYCLES consecutive samples: accept it.
            r_cnt   <= '0;
            r_level <= w_s;
            r_press <= w_s;
            r_rel   <= ~w_s;
            if (w_s) r_led <= ~r_led;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;
   assign o_rel   = r_rel;
   assign o_led   = r_led;

endmodule

// File: rtl/buttons_debounce.sv
// N-channel pushbutton front end: polarity fix, then one debounce_channel per pin.
module buttons_debounce
   import buttons_pkg::*;
#(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_rel,
   output logic [N_BTN-1:0] led
);

   // After this point 1 always means pressed, so channel reset value 0 is "not pressed".
   logic [N_BTN-1:0] w_btn;
   assign w_btn = BTN_ACTIVE_LOW ? ~btn : btn;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rstn   (rstn),
         .i_pin  (w_btn[i]),
         .o_level(btn_level[i]),
         .o_press(btn_press[i]),
         .o_rel  (btn_rel[i]),
         .o_led  (led[i])
      );
   end

endmodule

// File: tb/tb_buttons_debounce.sv
// Self-checking bench for buttons_debounce (DEBOUNCE_CYCLES=4, 100 ns clock).
module tb_buttons_debounce;

   typedef struct {
      logic [4:0] btn;
      int         cyc;
      logic [4:0] lvl;
      logic [4:0] led;
      logic [4:0] prs;
      logic [4:0] rl;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [4:0] btn, lvl, prs, rel, led;
   logic [4:0] btn_al, lvl_al, prs_al, rel_al, led_al;

   int n_chk  = 0;
   int n_pass = 0;
   int pc[5]  = '{default: 0};
   int rc[5]  = '{default: 0};
   int p0[5]  = '{default: 0};
   int r0[5]  = '{default: 0};
   int both_err = 0;

   vec_t tbl[11];
   vec_t sb_q[$];
   vec_t e;

   always #50 clk = ~clk;

   buttons_debounce #(.N_BTN(5), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .rstn(rstn), .btn(btn),
      .btn_level(lvl), .btn_press(prs), .btn_rel(rel), .led(led));

   buttons_debounce #(.N_BTN(5), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rstn(rstn), .btn(btn_al),
      .btn_level(lvl_al), .btn_press(prs_al), .btn_rel(rel_al), .led(led_al));

   // Pulse counters sampled on the inactive edge.
   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) begin
         pc[i] = pc[i] + int'(prs[i]);
         rc[i] = rc[i] + int'(rel[i]);
      end
      if ((prs & rel) != 5'b0) both_err = both_err + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 5; i++) begin
         p0[i] = pc[i];
         r0[i] = rc[i];
      end
   endtask

   // Per-channel pulse count since snap(), 2 bits per channel, saturating at 3.
   function automatic logic [9:0] dcnt(input bit rel_sel);
      logic [9:0] v;
      int d;
      v = '0;
      for (int i = 0; i < 5; i++) begin
         d = rel_sel ? rc[i] - r0[i] : pc[i] - p0[i];
         if (d > 3) d = 3;
         v[2*i +: 2] = 2'(d);
      end
      return v;
   endfunction

   // Expected dcnt for "exactly one pulse on each masked channel".
   function automatic logic [9:0] enc(input logic [4:0] m);
      logic [9:0] v;
      v = '0;
      for (int i = 0; i < 5; i++) v[2*i +: 2] = {1'b0, m[i]};
      return v;
   endfunction

   initial begin
      tbl[0]  = '{5'b10101, 8, 5'b10101, 5'b10101, 5'b10101, 5'b00000};
      tbl[1]  = '{5'b10001, 8, 5'b10001, 5'b10101, 5'b00000, 5'b00100};
      tbl[2]  = '{5'b10101, 8, 5'b10101, 5'b10001, 5'b00100, 5'b00000};
      tbl[3]  = '{5'b10001, 8, 5'b10001, 5'b10001, 5'b00000, 5'b00100};
      tbl[4]  = '{5'b00000, 8, 5'b00000, 5'b10001, 5'b00000, 5'b10001};
      tbl[5]  = '{5'b01010, 3, 5'b00000, 5'b10001, 5'b00000, 5'b00000};
      tbl[6]  = '{5'b01010, 3, 5'b01010, 5'b11011, 5'b01010, 5'b00000};
      tbl[7]  = '{5'b00000, 2, 5'b01010, 5'b11011, 5'b00000, 5'b00000};
      tbl[8]  = '{5'b01010, 8, 5'b01010, 5'b11011, 5'b00000, 5'b00000};
      tbl[9]  = '{5'b11111, 8, 5'b11111, 5'b01110, 5'b10101, 5'b00000};
      tbl[10] = '{5'b00000, 8, 5'b00000, 5'b01110, 5'b00000, 5'b11111};

      // Reset with all pins driven pressed.
      rstn = 1'b0; btn = 5'b11111; btn_al = 5'b11111;
      #10;
      chk("rst_level", 32'(lvl), 32'h0);
      chk("rst_press", 32'(prs), 32'h0);
      chk("rst_rel",   32'(rel), 32'h0);
      chk("rst_led",   32'(led), 32'h0);
      chk("rst_al_outs", 32'({lvl_al, prs_al, rel_al, led_al}), 32'h0);
      step(3);
      rstn = 1'b1; btn = 5'b00000;
      snap();
      step(20);
      chk("idle_level_led", 32'({lvl, led}), 32'h0);
      chk("idle_press_cnt", 32'(dcnt(1'b0)), 32'h0);
      chk("idle_rel_cnt",   32'(dcnt(1'b1)), 32'h0);
      chk("idle_al_outs", 32'({lvl_al, led_al}), 32'h0);

      // Clean press / release on channel 0: 6-edge latency.
      btn = 5'b00001; snap();
      step(5);
      chk("press0_lvl_e5", 32'(lvl), 32'h0);
      step(1);
      chk("press0_lvl_e6", 32'(lvl), 32'h01);
      chk("press0_pulse",  32'(prs), 32'h01);
      chk("press0_led",    32'(led), 32'h01);
      step(1);
      chk("press0_pulse_end", 32'(prs), 32'h0);
      step(10);
      chk("press0_no_repeat", 32'(dcnt(1'b0)), 32'(enc(5'b00001)));
      btn = 5'b00000;
      step(5);
      chk("rel0_lvl_e5", 32'(lvl), 32'h01);
      step(1);
      chk("rel0_lvl_e6", 32'(lvl), 32'h0);
      chk("rel0_pulse",  32'(rel), 32'h01);
      chk("rel0_led",    32'(led), 32'h01);
      step(1);
      chk("rel0_pulse_end", 32'(rel), 32'h0);

      // Bounce on channel 1, then hold.
      snap();
      btn = 5'b00010; step(1);
      btn = 5'b00000; step(1);
      btn = 5'b00010; step(1);
      btn = 5'b00000; step(1);
      btn = 5'b00010;
      step(5);
      chk("bounce_lvl_e5", 32'(lvl), 32'h0);
      chk("bounce_no_early", 32'(dcnt(1'b0)), 32'h0);
      step(1);
      chk("bounce_lvl_e6", 32'(lvl), 32'h02);
      chk("bounce_pulse",  32'(prs), 32'h02);
      chk("bounce_led",    32'(led), 32'h03);
      step(1);
      chk("bounce_one_press", 32'(dcnt(1'b0)), 32'(enc(5'b00010)));

      // Three-sample glitch on channel 2 is rejected.
      snap();
      btn = 5'b00110; step(3);
      btn = 5'b00010; step(10);
      chk("glitch3_lvl",   32'(lvl), 32'h02);
      chk("glitch3_press", 32'(dcnt(1'b0)), 32'h0);
      btn = 5'b00000; snap(); step(8);
      chk("bounce_release", 32'(dcnt(1'b1)), 32'(enc(5'b00010)));

      // Fresh reset, then table of multi-channel vectors.
      rstn = 1'b0; step(1); rstn = 1'b1;
      for (int i = 0; i < 11; i++) begin
         btn = tbl[i].btn;
         sb_q.push_back(tbl[i]);
         snap();
         step(tbl[i].cyc);
         e = sb_q.pop_front();
         chk($sformatf("vec%0d_level", i), 32'(lvl), 32'(e.lvl));
         chk($sformatf("vec%0d_led",   i), 32'(led), 32'(e.led));
         chk($sformatf("vec%0d_press", i), 32'(dcnt(1'b0)), 32'(enc(e.prs)));
         chk($sformatf("vec%0d_rel",   i), 32'(dcnt(1'b1)), 32'(enc(e.rl)));
      end

      // Reset mid-count on channel 3 while the pin stays pressed.
      btn = 5'b01000; snap();
      step(4);
      rstn = 1'b0; #1;
      chk("midrst_led", 32'(led), 32'h0);
      chk("midrst_lvl", 32'(lvl), 32'h0);
      step(1);
      rstn = 1'b1;
      step(5);
      chk("midrst_lvl_e5",  32'(lvl), 32'h0);
      chk("midrst_no_early", 32'(dcnt(1'b0)), 32'h0);
      step(1);
      chk("midrst_lvl_e6", 32'(lvl), 32'h08);
      chk("midrst_pulse",  32'(prs), 32'h08);
      chk("midrst_led_e6", 32'(led), 32'h08);
      btn = 5'b00000; step(8);

      // Active-low instance: channel 4 pin pulled low.
      chk("al_idle", 32'({lvl_al, prs_al, rel_al, led_al}), 32'h0);
      btn_al = 5'b01111;
      step(5);
      chk("al_lvl_e5", 32'(lvl_al), 32'h0);
      step(1);
      chk("al_lvl_e6", 32'(lvl_al), 32'h10);
      chk("al_pulse",  32'(prs_al), 32'h10);
      chk("al_led",    32'(led_al), 32'h10);
      step(1);
      chk("al_pulse_end", 32'(prs_al), 32'h0);

      chk("no_both_pulses", 32'(both_err), 32'h0);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
